// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction register / control FSM.
package cpu_pkg;

  // Instruction and immediate width; the decode assumes a 16-bit word.
  localparam int IR_W = 16;

  // Controller states.
  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    WR_IMM,
    GET_A,
    GET_B,
    EXEC,
    WR_REG
  } state_t;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    INS_UNDEF,
    INS_MOV_IMM,
    INS_MOV_REG,
    INS_MVN,
    INS_ADD,
    INS_CMP,
    INS_AND
  } instr_cls_t;

  // Opcode field values (IR[15:13]).
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field values (IR[12:11]).
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU operation encodings.
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Write-back mux encodings.
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // ALU operation used in the EXEC state for a given instruction class.
  function automatic logic [1:0] alu_op_for(input instr_cls_t cls);
    logic [1:0] op_sel;
    op_sel = ALU_ADD;
    case (cls)
      INS_CMP: op_sel = ALU_SUB;
      INS_AND: op_sel = ALU_AND;
      INS_MVN: op_sel = ALU_NOTB;
      default: op_sel = ALU_ADD;
    endcase
    return op_sel;
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction handshake plus every datapath control line driven by cpu_ctrl.
// master: the environment feeding instructions and consuming controls.
// slave:  the controller itself.
interface cpu_ctrl_if #(
  parameter int DATA_W = cpu_pkg::IR_W
);
  logic [DATA_W-1:0] in;
  logic              load;
  logic              s;
  logic              w;
  logic [2:0]        readnum;
  logic [2:0]        writenum;
  logic              write;
  logic [1:0]        vsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        shift;
  logic [1:0]        ALUop;
  logic [DATA_W-1:0] sximm8;
  logic [DATA_W-1:0] sximm5;

  modport master (
    output in, load, s,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    input  in, load, s,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits the IR into fields, sign-extends
// the immediates and classifies the instruction.
module instr_dec
  import cpu_pkg::*;
#(
  parameter int DATA_W = IR_W
) (
  input  logic [DATA_W-1:0] ir,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [1:0]        sh,
  output logic [2:0]        rm,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output instr_cls_t        cls
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  // Low immediate bits pass straight through; upper bits replicate the sign.
  assign sximm8[7:0] = ir[7:0];
  assign sximm5[4:0] = ir[4:0];

  genvar gi;
  generate
    for (gi = 8; gi < DATA_W; gi++) begin : g_sx8
      assign sximm8[gi] = ir[7];
    end
    for (gi = 5; gi < DATA_W; gi++) begin : g_sx5
      assign sximm5[gi] = ir[4];
    end
  endgenerate

  // Map opcode/op pairs onto instruction classes; anything unlisted is undefined.
  always_comb begin
    cls = INS_UNDEF;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      cls = INS_MOV_IMM;
      else if (op == OP_MOV_REG) cls = INS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = INS_ADD;
        OP_CMP:  cls = INS_CMP;
        OP_AND:  cls = INS_AND;
        default: cls = INS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register and multi-cycle control FSM for the 16-bit datapath.
// All control outputs are Moore outputs of the state register and the IR.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = IR_W   // only 16 is meaningful for this instruction set
) (
  input  logic       clk,
  input  logic       reset,
  cpu_ctrl_if.slave  bus
);

  logic [DATA_W-1:0] ir_reg;
  state_t            state_reg;
  state_t            state_next;

  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [1:0]        sh;
  logic [2:0]        rm;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] sximm8;
  instr_cls_t        cls;

  instr_dec #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir_reg),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  // State and IR registers; IR only accepts a new word while idle so it stays
  // stable for the whole instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= WAIT;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (bus.load && (state_reg == WAIT)) begin
        ir_reg <= bus.in;
      end
    end
  end

  logic       w_c;
  logic       write_c;
  logic       loada_c;
  logic       loadb_c;
  logic       loadc_c;
  logic       loads_c;
  logic       asel_c;
  logic [1:0] vsel_c;
  logic [1:0] aluop_c;
  logic [2:0] readnum_c;
  logic [2:0] writenum_c;

  // Next-state sequencing and per-state control decode.
  always_comb begin
    state_next = state_reg;
    w_c        = 1'b0;
    write_c    = 1'b0;
    loada_c    = 1'b0;
    loadb_c    = 1'b0;
    loadc_c    = 1'b0;
    loads_c    = 1'b0;
    asel_c     = 1'b0;
    vsel_c     = VSEL_C;
    aluop_c    = ALU_ADD;
    readnum_c  = 3'd0;
    writenum_c = 3'd0;

    case (state_reg)
      WAIT: begin
        w_c = 1'b1;
        if (bus.s) state_next = DECODE;
      end
      DECODE: begin
        case (cls)
          INS_MOV_IMM:          state_next = WR_IMM;
          INS_MOV_REG, INS_MVN: state_next = GET_B;
          INS_ADD, INS_CMP,
          INS_AND:              state_next = GET_A;
          default:              state_next = WAIT;
        endcase
      end
      WR_IMM: begin
        writenum_c = rn;
        vsel_c     = VSEL_IMM;
        write_c    = 1'b1;
        state_next = WAIT;
      end
      GET_A: begin
        readnum_c  = rn;
        loada_c    = 1'b1;
        state_next = GET_B;
      end
      GET_B: begin
        readnum_c  = rm;
        loadb_c    = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        aluop_c = alu_op_for(cls);
        // MOV reg is computed as 0 + shifted B.
        asel_c  = (cls == INS_MOV_REG);
        if (cls == INS_CMP) begin
          loads_c    = 1'b1;
          state_next = WAIT;
        end else begin
          loadc_c    = 1'b1;
          state_next = WR_REG;
        end
      end
      WR_REG: begin
        writenum_c = rd;
        vsel_c     = VSEL_C;
        write_c    = 1'b1;
        state_next = WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

  assign bus.w        = w_c;
  assign bus.write    = write_c;
  assign bus.loada    = loada_c;
  assign bus.loadb    = loadb_c;
  assign bus.loadc    = loadc_c;
  assign bus.loads    = loads_c;
  assign bus.asel     = asel_c;
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = vsel_c;
  assign bus.ALUop    = aluop_c;
  assign bus.readnum  = readnum_c;
  assign bus.writenum = writenum_c;
  assign bus.shift    = sh;
  assign bus.sximm8   = sximm8;
  assign bus.sximm5   = sximm5;

endmodule
